// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Sequencer states: one access in flight at most.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// Saturating count of arbitrations fetch has lost while it was requesting.
// Once it saturates, force_if hands the next arbitration to fetch.
module unified_mem_arbiter_starve_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_idle,
  input  logic if_req,
  input  logic d_win,
  output logic force_if
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_if = (cnt_q == CNT_MAX);

  // Only arbitration cycles (IDLE) move the counter: a fetch win or an idle fetch clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_idle) begin
      if (!if_req) begin
        cnt_d = '0;
      end else if (d_win) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store path. Data normally wins; the starvation counter guarantees fetch
// progress. One access is in flight at a time; stall freezes the core meanwhile.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int WAIT_W = $clog2(RD_LAT + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic force_if, if_win, d_win;
  logic rv_last, done, other_req;

  // Fetch wins when alone or when it has been starved long enough.
  assign if_win = if_req && (!d_req || force_if);
  assign d_win  = d_req && !if_win;

  unified_mem_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .arb_idle (state_q == ST_IDLE),
    .if_req   (if_req),
    .d_win    (d_win),
    .force_if (force_if)
  );

  // Next-state and registered memory command for the access sequencer.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d  = ST_ISSUE;
          mem_en_d = 1'b1;
          if (if_win) begin
            owner_d    = OWN_IF;
            mem_addr_d = if_addr;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(RD_LAT);
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_W'(1)) state_d = ST_IDLE;
        else                          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and command registers; reset abandons any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign if_gnt    = (state_q == ST_ISSUE) && (owner_q == OWN_IF);
  assign d_gnt     = (state_q == ST_ISSUE) && (owner_q == OWN_D);
  assign rv_last   = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_W'(1));
  assign if_rvalid = rv_last && (owner_q == OWN_IF);
  assign d_rvalid  = rv_last && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // The completing cycle releases the core unless the other requester is still waiting;
  // the owner's own request line is either the held store request or a new one it may
  // present as soon as its data arrives, so it does not keep the stall up.
  assign done      = rv_last || ((state_q == ST_ISSUE) && mem_we_q);
  assign other_req = (owner_q == OWN_IF) ? d_req : if_req;
  assign stall     = ((state_q != ST_IDLE) || if_req || d_req) && !(done && !other_req);

endmodule
